// File: rtl/tape_mem_arbiter.sv
// Shares one byte-wide memory port between two round-robin read clients (tape player A,
// auxiliary reader B) and a write client with a one-deep pending slot that wins at IDLE exit.
module tape_mem_arbiter #(
    parameter int AW      = 25,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk_sys,
    input  logic          reset,
    output logic          a_rd_en,
    input  logic          a_rd,
    input  logic [AW-1:0] a_addr,
    output logic [7:0]    a_din,
    output logic          b_rd_en,
    input  logic          b_rd,
    input  logic [AW-1:0] b_addr,
    output logic [7:0]    b_din,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic          mem_ack,
    input  logic [7:0]    mem_rdata,
    output logic          wr_overrun,
    output logic          timeout_err,
    output logic          busy
);

    localparam int GW = $clog2(GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_OFFER, S_READ, S_WRITE} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [TW-1:0]   to_q, to_d;
    logic            rr_q, rr_d;              // 0 = client A, 1 = client B
    logic            pend_q, pend_d;
    logic [AW-1:0]   pend_addr_q, pend_addr_d;
    logic [7:0]      pend_data_q, pend_data_d;
    logic            a_rd_en_q, a_rd_en_d, b_rd_en_q, b_rd_en_d;
    logic [7:0]      a_din_q, a_din_d, b_din_q, b_din_d;
    logic            mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]      mem_wdata_q, mem_wdata_d;
    logic            wr_overrun_q, wr_overrun_d, timeout_err_q, timeout_err_d;
    logic            busy_q, busy_d;
    logic            retire, finish, sel_rd;
    logic [7:0]      rd_byte;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        to_d          = to_q;
        rr_d          = rr_q;
        pend_d        = pend_q;
        pend_addr_d   = pend_addr_q;
        pend_data_d   = pend_data_q;
        a_rd_en_d     = a_rd_en_q;
        b_rd_en_d     = b_rd_en_q;
        a_din_d       = a_din_q;
        b_din_d       = b_din_q;
        mem_rd_d      = mem_rd_q;
        mem_wr_d      = mem_wr_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        wr_overrun_d  = wr_overrun_q;
        timeout_err_d = timeout_err_q;
        retire        = 1'b0;
        finish        = mem_ack || (to_q == TO_LAST);
        sel_rd        = rr_q ? b_rd : a_rd;
        rd_byte       = mem_ack ? mem_rdata : 8'hFF;

        case (state_q)
            S_IDLE: begin
                if (gap_q <= GW'(1)) begin
                    to_d = '0;
                    if (pend_q) begin
                        state_d     = S_WRITE;
                        mem_wr_d    = 1'b1;
                        mem_addr_d  = pend_addr_q;
                        mem_wdata_d = pend_data_q;
                    end else begin
                        state_d   = S_OFFER;
                        a_rd_en_d = ~rr_q;
                        b_rd_en_d = rr_q;
                    end
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            S_OFFER: begin
                if (sel_rd) begin
                    state_d    = S_READ;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = rr_q ? b_addr : a_addr;
                end else begin
                    state_d   = S_IDLE;
                    gap_d     = GAP_INIT;
                    a_rd_en_d = 1'b0;
                    b_rd_en_d = 1'b0;
                    rr_d      = ~rr_q;
                end
            end
            S_READ: begin
                if (finish) begin
                    if (rr_q) b_din_d = rd_byte;
                    else      a_din_d = rd_byte;
                    if (!mem_ack) timeout_err_d = 1'b1;
                    state_d   = S_IDLE;
                    gap_d     = GAP_INIT;
                    mem_rd_d  = 1'b0;
                    a_rd_en_d = 1'b0;
                    b_rd_en_d = 1'b0;
                    rr_d      = ~rr_q;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_WRITE: begin
                if (finish) begin
                    if (!mem_ack) timeout_err_d = 1'b1;
                    state_d  = S_IDLE;
                    gap_d    = GAP_INIT;
                    mem_wr_d = 1'b0;
                    retire   = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new write arriving as the old one retires simply becomes the pending one.
        if (wr_req) begin
            pend_d      = 1'b1;
            pend_addr_d = wr_addr;
            pend_data_d = wr_data;
            if (pend_q && !retire) wr_overrun_d = 1'b1;
        end else if (retire) begin
            pend_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE) || pend_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= S_IDLE;
            gap_q         <= GAP_INIT;
            to_q          <= '0;
            rr_q          <= 1'b0;
            pend_q        <= 1'b0;
            pend_addr_q   <= '0;
            pend_data_q   <= '0;
            a_rd_en_q     <= 1'b0;
            b_rd_en_q     <= 1'b0;
            a_din_q       <= 8'hFF;
            b_din_q       <= 8'hFF;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            wr_overrun_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            to_q          <= to_d;
            rr_q          <= rr_d;
            pend_q        <= pend_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            a_rd_en_q     <= a_rd_en_d;
            b_rd_en_q     <= b_rd_en_d;
            a_din_q       <= a_din_d;
            b_din_q       <= b_din_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            wr_overrun_q  <= wr_overrun_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign a_rd_en     = a_rd_en_q;
    assign b_rd_en     = b_rd_en_q;
    assign a_din       = a_din_q;
    assign b_din       = b_din_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wr_overrun  = wr_overrun_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_tape_mem_arbiter.sv
// Directed bench for tape_mem_arbiter: idle offers, single read, round-robin, write priority,
// write overrun, timeout and reset, against a small ack-latency memory responder.
module tb_tape_mem_arbiter;
    localparam int AW = 25;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic          a_rd, b_rd, wr_req;
    logic [AW-1:0] a_addr, b_addr, wr_addr;
    logic [7:0]    wr_data;
    logic          a_rd_en, b_rd_en, mem_rd, mem_wr, wr_overrun, timeout_err, busy;
    logic [7:0]    a_din, b_din, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          mem_ack   = 1'b0;
    logic [7:0]    mem_rdata = 8'h00;

    int            checks   = 0;
    int            failures = 0;
    int            ack_lat  = 0;
    logic [7:0]    rdata_xor = 8'h00;
    int            hi_cnt   = 0;
    logic [AW-1:0] rd_log [8];
    int            rd_n = 0;
    int            wr_n = 0;
    logic [AW-1:0] last_wa = '0;
    logic [7:0]    last_wd = '0;
    bit            both_en  = 1'b0;
    bit            both_mem = 1'b0;

    tape_mem_arbiter #(.AW(AW), .GAP(2), .TIMEOUT(15)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .a_rd_en(a_rd_en), .a_rd(a_rd), .a_addr(a_addr), .a_din(a_din),
        .b_rd_en(b_rd_en), .b_rd(b_rd), .b_addr(b_addr), .b_din(b_din),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wr_overrun(wr_overrun), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Memory responder: ack on the ack_lat-th cycle a strobe is high (0 = never ack).
    always @(negedge clk_sys) begin
        if (mem_rd || mem_wr) hi_cnt = hi_cnt + 1;
        else                  hi_cnt = 0;
        mem_ack   = (mem_rd || mem_wr) && (ack_lat != 0) && (hi_cnt == ack_lat);
        mem_rdata = mem_addr[7:0] ^ rdata_xor;
    end

    always @(posedge clk_sys) begin
        if (!reset && mem_ack && mem_rd && rd_n < 8) begin
            rd_log[rd_n] = mem_addr;
            rd_n = rd_n + 1;
        end
        if (!reset && mem_ack && mem_wr) begin
            wr_n    = wr_n + 1;
            last_wa = mem_addr;
            last_wd = mem_wdata;
        end
        if (a_rd_en && b_rd_en) both_en = 1'b1;
        if (mem_rd && mem_wr)   both_mem = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return a_rd_en;
            1:       return b_rd_en;
            2:       return mem_rd;
            default: return mem_wr;
        endcase
    endfunction

    task automatic wait_level(input int which, input logic lvl, input string tag);
        for (int i = 0; i < 64; i++) begin
            if (sig(which) === lvl) break;
            tick();
        end
        check(tag, 32'(sig(which)), 32'(lvl));
    endtask

    task automatic pulse_wr(input logic [AW-1:0] addr, input logic [7:0] data);
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_req  = 1'b0;
    endtask

    logic [11:0]   a_tr, b_tr;
    logic          strobe_any;
    int            cnt, w0;
    logic [AW-1:0] seen;

    initial begin
        a_rd = 0; b_rd = 0; a_addr = '0; b_addr = '0;
        wr_req = 0; wr_addr = '0; wr_data = '0;
        a_tr = '0; b_tr = '0; strobe_any = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_a_rd_en", 32'(a_rd_en), 0);
        check("rst_b_rd_en", 32'(b_rd_en), 0);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_wr", 32'(mem_wr), 0);
        check("rst_a_din", 32'(a_din), 32'hFF);
        check("rst_b_din", 32'(b_din), 32'hFF);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_flags", {30'd0, wr_overrun, timeout_err}, 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;

        // Idle: single-cycle offers alternate A, B with two low cycles between
        for (int i = 0; i < 12; i++) begin
            tick();
            a_tr = {a_tr[10:0], a_rd_en};
            b_tr = {b_tr[10:0], b_rd_en};
            strobe_any = strobe_any | mem_rd | mem_wr;
        end
        check("idle_a_trace", 32'(a_tr), 32'b010000010000);
        check("idle_b_trace", 32'(b_tr), 32'b000010000010);
        check("idle_no_mem", 32'(strobe_any), 0);
        check("idle_a_din", 32'(a_din), 32'hFF);
        check("idle_b_din", 32'(b_din), 32'hFF);

        // Single A read, ack on third mem_rd cycle, data 0x23^0x79 = 0x5A
        a_rd = 1; a_addr = 25'h123; ack_lat = 3; rdata_xor = 8'h79;
        wait_level(0, 1'b1, "t2_grant");
        cnt = 0; seen = '0;
        while (a_rd_en && cnt < 20) begin
            if (mem_rd) seen = mem_addr;
            cnt = cnt + 1;
            tick();
        end
        a_rd = 0;
        check("t2_en_cycles", 32'(cnt), 4);
        check("t2_mem_addr", 32'(seen), 32'h123);
        check("t2_a_din", 32'(a_din), 32'h5A);

        // Both clients requesting: strict alternation, each din updated only in its window
        a_addr = 25'h10; a_rd = 1; ack_lat = 1; rdata_xor = 8'h00; rd_n = 0;
        wait_level(1, 1'b1, "t3_b_offer");
        tick();
        b_addr = 25'h20; b_rd = 1;
        wait_level(0, 1'b1, "t3_a_rise");
        wait_level(0, 1'b0, "t3_a_fall");
        check("t3_a_din_1", 32'(a_din), 32'h10);
        check("t3_b_din_1", 32'(b_din), 32'hFF);
        wait_level(1, 1'b1, "t3_b_rise");
        wait_level(1, 1'b0, "t3_b_fall");
        check("t3_b_din_2", 32'(b_din), 32'h20);
        check("t3_a_din_2", 32'(a_din), 32'h10);
        for (int i = 0; i < 40; i++) begin
            if (rd_n >= 4) break;
            tick();
        end
        b_rd = 0; a_addr = 25'h30; ack_lat = 4;
        check("t3_rd_count", 32'(rd_n >= 4), 1);
        check("t3_log0", 32'(rd_log[0]), 32'h10);
        check("t3_log1", 32'(rd_log[1]), 32'h20);
        check("t3_log2", 32'(rd_log[2]), 32'h10);
        check("t3_log3", 32'(rd_log[3]), 32'h20);

        // Write during an A read: read finishes, then write, then B's turn
        wait_level(2, 1'b1, "t4_rd");
        pulse_wr(25'h40, 8'hC3);
        a_rd = 0;
        w0 = wr_n;
        wait_level(3, 1'b1, "t4_wr");
        check("t4_wdata", 32'(mem_wdata), 32'hC3);
        check("t4_waddr", 32'(mem_addr), 32'h40);
        check("t4_read_first", 32'(a_din), 32'h30);
        check("t4_no_en", {30'd0, a_rd_en, b_rd_en}, 0);
        check("t4_busy", 32'(busy), 1);
        wait_level(3, 1'b0, "t4_wr_done");
        check("t4_wr_count", 32'(wr_n), 32'(w0 + 1));
        check("t4_last_wd", 32'(last_wd), 32'hC3);
        for (int i = 0; i < 20; i++) begin
            if (a_rd_en || b_rd_en) break;
            tick();
        end
        check("t4_rr_b", {30'd0, a_rd_en, b_rd_en}, 32'b01);

        // Two writes while a read is in flight: second overwrites first
        a_rd = 1; a_addr = 25'h50; ack_lat = 6;
        wait_level(2, 1'b1, "t5_rd");
        a_rd = 0;
        pulse_wr(25'h60, 8'h11);
        tick();
        pulse_wr(25'h70, 8'h22);
        check("t5_overrun", 32'(wr_overrun), 1);
        w0 = wr_n;
        wait_level(3, 1'b1, "t5_wr");
        check("t5_wdata", 32'(mem_wdata), 32'h22);
        check("t5_waddr", 32'(mem_addr), 32'h70);
        wait_level(3, 1'b0, "t5_wr_done");
        repeat (12) tick();
        check("t5_one_write", 32'(wr_n), 32'(w0 + 1));
        check("t5_a_din", 32'(a_din), 32'h50);

        // Timeout: ack withheld, mem_rd held exactly 15 cycles
        ack_lat = 0; a_rd = 1; a_addr = 25'h99;
        wait_level(2, 1'b1, "t6_rd");
        a_rd = 0;
        cnt = 0;
        while (mem_rd && cnt < 40) begin
            cnt = cnt + 1;
            tick();
        end
        check("t6_rd_cycles", 32'(cnt), 15);
        check("t6_a_din", 32'(a_din), 32'hFF);
        check("t6_a_rd_en", 32'(a_rd_en), 0);
        check("t6_timeout_err", 32'(timeout_err), 1);

        // Reset during an access drops everything on the next edge
        a_rd = 1;
        wait_level(2, 1'b1, "t7_rd");
        reset = 1'b1;
        tick();
        check("t7_strobes", {28'd0, a_rd_en, b_rd_en, mem_rd, mem_wr}, 0);
        check("t7_flags", {30'd0, wr_overrun, timeout_err}, 0);
        check("t7_busy", 32'(busy), 0);
        reset = 1'b0; a_rd = 0;
        repeat (3) tick();
        check("t7_post_mem_rd", 32'(mem_rd), 0);

        check("never_both_en", 32'(both_en), 0);
        check("never_both_mem", 32'(both_mem), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tape_mem_arbiter.md
Name: tape_mem_arbiter

Overview:
- Shares one byte-wide memory port (SDRAM tape/snapshot buffer) between two read clients and one write client.
- Read client A is the tape player. Read client B is an auxiliary reader (e.g. snapshot/ROM loader). The write client is the ioctl download path.
- Read clients use the per-client rd_en strobe handshake the tape player already speaks. Writes take priority over reads; reads alternate round-robin.

Parameters:
AW, 25, address width of all address ports.
GAP, 2, clk_sys cycles spent in IDLE between consecutive grants (min 1).
TIMEOUT, 1023, max cycles to wait for mem_ack before aborting an access (min 1).

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high.
a_rd_en  out  1  client A grant strobe: high only during A's offer/access window.
a_rd  in  1  client A read request; valid while a_rd_en high.
a_addr  in  AW  client A read address.
a_din  out  8  client A read data.
b_rd_en  out  1  client B grant strobe; same rules as a_rd_en.
b_rd  in  1  client B read request.
b_addr  in  AW  client B read address.
b_din  out  8  client B read data.
wr_req  in  1  one-cycle write pulse from download path.
wr_addr  in  AW  write address, sampled with wr_req.
wr_data  in  8  write data, sampled with wr_req.
mem_rd  out  1  memory read request; held until ack or timeout.
mem_wr  out  1  memory write request; held until ack or timeout.
mem_addr  out  AW  memory address.
mem_wdata  out  8  memory write data.
mem_ack  in  1  one-cycle completion pulse; mem_rdata valid in the same cycle.
mem_rdata  in  8  memory read data.
wr_overrun  out  1  sticky: pending write was overwritten.
timeout_err  out  1  sticky: an access timed out.
busy  out  1  state != IDLE or a write is pending.

Behaviour:
- All outputs are registered.
- Reset values: a_rd_en = b_rd_en = mem_rd = mem_wr = 0; a_din = b_din = 8'hFF; mem_addr = 0; mem_wdata = 0; wr_overrun = timeout_err = 0; write pending cleared; rr pointer = A; state = IDLE with gap counter = GAP.
- Reset mid-access drops all strobes on the next edge. A mem_ack arriving after reset is ignored.
- Write capture: wr_req latches wr_addr/wr_data into a one-deep pending slot.
  - wr_req while pending is valid and not being retired that cycle: overwrite the slot and set wr_overrun.
  - wr_req in the same cycle the pending write completes: the new write becomes pending (set wins); no overrun.
- IDLE: all rd_en low. Count GAP cycles. At the last cycle, go to WRITE if a write is pending, otherwise to OFFER for client rr.
- OFFER (exactly 1 cycle): rd_en of client X = rr is high. Sample X_rd in that cycle.
  - X_rd = 1: latch X_addr into mem_addr, go to READ; mem_rd = 1 from the next cycle; X_rd_en stays high.
  - X_rd = 0: X_rd_en low next cycle, toggle rr, go to IDLE. No memory access.
- READ: hold mem_rd and mem_addr.
  - On the cycle mem_ack = 1: next edge sets X_din = mem_rdata, mem_rd = 0, X_rd_en = 0; toggle rr; go to IDLE.
  - X_din is then stable at least until X's next grant ends. The client captures on its first rd_en-low cycle.
- WRITE: mem_wr = 1 with the pending addr/data until mem_ack. Then mem_wr = 0, clear pending, go to IDLE. rr is unchanged. No rd_en is asserted.
- Timeout: the counter starts at mem_rd/mem_wr assertion. After TIMEOUT cycles without ack, abort the access like an ack with these differences:
  - Read: X_din = 8'hFF.
  - Write: the pending write is dropped.
  - In both cases timeout_err is set.
- Read latency: OFFER at cycle t, mem_rd at t+1, ack at t+k (k ≥ 1), X_din valid and X_rd_en low at t+k+1.
- Fairness: a client that idles forfeits its turn. With both clients always requesting, grants strictly alternate A, B, A, ...
- Writes preempt only at IDLE exit, never an in-flight read.
- rd_en of both clients is never high simultaneously. mem_rd and mem_wr are never high simultaneously.
- wr_overrun and timeout_err clear only on reset.

Test Plan:
- Reset then idle, with a_rd = b_rd = 0 → a_rd_en/b_rd_en each pulse 1 cycle alternately, separated by GAP = 2 low cycles; mem_rd never asserted; a_din = b_din = 8'hFF.
- a_rd = 1, a_addr = 0x000123, memory acks 3 cycles after mem_rd with 0x5A → mem_addr = 0x000123; a_rd_en high 4 cycles; a_din = 0x5A on the first a_rd_en-low cycle.
- Both clients continuously requesting (A addr 0x10, B addr 0x20, ack latency 1) → mem_addr sequence 0x10, 0x20, 0x10, 0x20; each a_din/b_din is updated only in its own window.
- wr_req (0x000040, 0xC3) during an A read → the read completes first; the next grant is WRITE with mem_wr = 1, mem_wdata = 0xC3; rr still points to B afterwards.
- Two wr_req pulses 1 cycle apart while a read is in flight → only the second write reaches memory; wr_overrun = 1.
- mem_ack withheld with TIMEOUT = 15 → mem_rd drops after 15 cycles, a_din = 8'hFF, timeout_err = 1; assert reset → timeout_err = 0, all strobes low next cycle.
